// File: rtl/vec_lane_seq.sv
// rtl/vec_lane_seq.sv - multicycle vector execution unit, LANES elements per cycle
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            launch a vector op (sampled only while ready=1)
//   ALUControl       op select: add, sub, and, orr, mov, eor (110/111 reserved)
//   vcount           active element count (0 or >VLEN means VLEN)
//   ra1, ra2, wa3    source A, source B and destination vector registers
//   ready            high in IDLE only
//   done             one-cycle completion pulse
//   VALUFlags        {N,Z,C,V} of the last completed op
//   swe, saddr, sidx, swd   scalar element write port (IDLE only)
//   srd              combinational read of element [saddr][sidx]
module vec_lane_seq #(
  parameter int WIDTH = 32,
  parameter int VLEN  = 8,
  parameter int LANES = 2,
  parameter int NVREG = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 ALUControl,
  input  logic [$clog2(VLEN+1)-1:0]  vcount,
  input  logic [$clog2(NVREG)-1:0]   ra1,
  input  logic [$clog2(NVREG)-1:0]   ra2,
  input  logic [$clog2(NVREG)-1:0]   wa3,
  output logic                       ready,
  output logic                       done,
  output logic [3:0]                 VALUFlags,
  input  logic                       swe,
  input  logic [$clog2(NVREG)-1:0]   saddr,
  input  logic [$clog2(VLEN)-1:0]    sidx,
  input  logic [WIDTH-1:0]           swd,
  output logic [WIDTH-1:0]           srd
);

  localparam int CW = $clog2(VLEN + 1);
  localparam int RW = $clog2(NVREG);
  localparam int IW = $clog2(VLEN);
  // idx can run one beat past count, so it needs room for VLEN+LANES
  localparam int XW = $clog2(VLEN + LANES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [NVREG][VLEN];

  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    ra1_q, ra2_q, wa3_q;
  logic [XW-1:0]    idx;
  logic             acc_z, acc_c, acc_v;

  logic [CW-1:0]    vcount_norm;
  logic [IW-1:0]    lane_i   [LANES];
  logic [WIDTH-1:0] lane_a   [LANES];
  logic [WIDTH-1:0] lane_b   [LANES];
  logic [WIDTH-1:0] lane_res [LANES];
  logic [LANES-1:0] lane_act, lane_c, lane_v;
  logic [WIDTH:0]   sum_w;
  logic             cyc_n, cyc_z, cyc_c, cyc_v;
  logic             last_beat, op_valid;

  assign vcount_norm = (vcount == '0 || vcount > CW'(VLEN)) ? CW'(VLEN) : vcount;
  assign op_valid    = (op_q <= 3'b101);
  assign last_beat   = (idx + XW'(LANES)) >= XW'(cnt_q);
  assign srd         = mem[saddr][sidx];

  // Per-lane element compute. Every element only reads its own index, so
  // writing back into a source register in the same cycle is safe.
  always_comb begin
    sum_w = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_i[j]   = IW'(idx + XW'(j));
      lane_act[j] = (idx + XW'(j)) < XW'(cnt_q);
      lane_a[j]   = mem[ra1_q][lane_i[j]];
      lane_b[j]   = mem[ra2_q][lane_i[j]];
      lane_res[j] = '0;
      lane_c[j]   = 1'b0;
      lane_v[j]   = 1'b0;
      case (op_q)
        3'b000: begin
          sum_w       = {1'b0, lane_a[j]} + {1'b0, lane_b[j]};
          lane_res[j] = sum_w[WIDTH-1:0];
          lane_c[j]   = sum_w[WIDTH];
          lane_v[j]   = (lane_a[j][WIDTH-1] == lane_b[j][WIDTH-1]) &&
                        (sum_w[WIDTH-1] != lane_a[j][WIDTH-1]);
        end
        3'b001: begin
          // A + ~B + 1: carry-out set means no borrow
          sum_w       = {1'b0, lane_a[j]} + {1'b0, ~lane_b[j]} + (WIDTH+1)'(1);
          lane_res[j] = sum_w[WIDTH-1:0];
          lane_c[j]   = sum_w[WIDTH];
          lane_v[j]   = (lane_a[j][WIDTH-1] != lane_b[j][WIDTH-1]) &&
                        (sum_w[WIDTH-1] != lane_a[j][WIDTH-1]);
        end
        3'b010:  lane_res[j] = lane_a[j] & lane_b[j];
        3'b011:  lane_res[j] = lane_a[j] | lane_b[j];
        3'b100:  lane_res[j] = lane_b[j];
        3'b101:  lane_res[j] = lane_a[j] ^ lane_b[j];
        default: lane_res[j] = '0;
      endcase
    end
  end

  // Flags of this beat; lanes ascend, so the last active lane supplies N.
  always_comb begin
    cyc_n = 1'b0;
    cyc_z = 1'b1;
    cyc_c = 1'b0;
    cyc_v = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (lane_act[j]) begin
        cyc_n = lane_res[j][WIDTH-1];
        cyc_z = cyc_z & (lane_res[j] == '0);
        cyc_c = cyc_c | lane_c[j];
        cyc_v = cyc_v | lane_v[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXEC;
      EXEC:    if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Control datapath. Flags land on the final EXEC edge so they are
  // already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      VALUFlags <= 4'b0000;
      op_q      <= '0;
      cnt_q     <= '0;
      ra1_q     <= '0;
      ra2_q     <= '0;
      wa3_q     <= '0;
      acc_z     <= 1'b1;
      acc_c     <= 1'b0;
      acc_v     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= ALUControl;
          cnt_q <= vcount_norm;
          ra1_q <= ra1;
          ra2_q <= ra2;
          wa3_q <= wa3;
          idx   <= '0;
          acc_z <= 1'b1;
          acc_c <= 1'b0;
          acc_v <= 1'b0;
        end
        EXEC: begin
          idx   <= idx + XW'(LANES);
          acc_z <= acc_z & cyc_z;
          acc_c <= acc_c | cyc_c;
          acc_v <= acc_v | cyc_v;
          if (last_beat && op_valid)
            VALUFlags <= {cyc_n, acc_z & cyc_z, acc_c | cyc_c, acc_v | cyc_v};
        end
        default: ;
      endcase
    end
  end

  // Vector storage: scalar port in IDLE, lane results in EXEC. Not reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && swe)
        mem[saddr][sidx] <= swd;
      if (state == EXEC && op_valid) begin
        for (int j = 0; j < LANES; j++)
          if (lane_act[j]) mem[wa3_q][lane_i[j]] <= lane_res[j];
      end
    end
  end

endmodule

// File: doc/vec_lane_seq.md
Name: vec_lane_seq

Overview:
- Multicycle vector execution unit for the vector extension; the next step after the fixed 5-lane single-cycle vector path.
- Holds NVREG vector registers of VLEN elements each. Executes an element-wise op over a programmable element count, LANES elements per cycle, under a start/ready/done handshake.
- Sits beside the scalar datapath. The scalar side loads and reads elements through a scalar port and consumes the aggregated NZCV flags.

Parameters:
- WIDTH, 32, element width in bits.
- VLEN, 8, elements per vector register; must be a multiple of LANES.
- LANES, 2, elements processed per cycle; 1 ≤ LANES ≤ VLEN.
- NVREG, 16, number of vector registers; power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request a vector op; sampled only when ready=1.
- ALUControl  in  3  op select: 000 add, 001 sub (A−B), 010 and, 011 orr, 100 mov (result=B), 101 eor; 110/111 reserved.
- vcount  in  clog2(VLEN+1)  number of active elements; 0 or any value >VLEN is treated as VLEN.
- ra1  in  clog2(NVREG)  source vector A.
- ra2  in  clog2(NVREG)  source vector B.
- wa3  in  clog2(NVREG)  destination vector.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse at op completion.
- VALUFlags  out  4  {N,Z,C,V} of the last completed op.
- swe  in  1  scalar element write enable.
- saddr  in  clog2(NVREG)  scalar port register select.
- sidx  in  clog2(VLEN)  scalar port element select.
- swd  in  WIDTH  scalar write data.
- srd  out  WIDTH  combinational read of element [saddr][sidx].

Behaviour:
- Reset values: ready=1, done=0, VALUFlags=0000, FSM=IDLE, element index=0. Vector storage is not cleared.
- Storage: NVREG×VLEN×WIDTH. Only two write sources: the scalar port and the EXEC lanes.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - On start=1, latch ALUControl, vcount (normalised), ra1, ra2, wa3; set idx=0; go to EXEC.
  - swe=1 writes swd to [saddr][sidx] at the clock edge.
  - If start and swe are both high in the same cycle, the scalar write happens first in priority; the op still launches and observes the written value.
- EXEC, each cycle:
  - For lanes j=0..LANES−1, element e=idx+j is active iff e<count.
  - Active elements: write result to [wa3][e] and accumulate flags.
  - Inactive elements: destination unchanged.
  - Then idx+=LANES. If idx+LANES ≥ count, go to DONE.
- Element i depends only on source element i, so wa3==ra1 and/or wa3==ra2 (in-place) is legal and must produce the correct result.
- DONE:
  - done=1 for exactly one cycle.
  - VALUFlags updated this cycle.
  - Return to IDLE; ready=1 the following cycle.
- Latency: done is high exactly ceil(count/LANES)+1 cycles after the edge that samples start. Back-to-back ops have a minimum of 1 IDLE cycle between them.
- Arithmetic is modulo 2^WIDTH.
  - add: C=carry-out, V=signed overflow.
  - sub: C=1 if no borrow (A≥B unsigned), V=signed overflow.
  - Logical ops and mov: C=0, V=0.
- Flag aggregation:
  - N = MSB of the result of the highest-index active element.
  - Z = 1 iff all active results are 0.
  - C = OR of per-element C.
  - V = OR of per-element V.
- Reserved ALUControl: the op sequences normally but performs no writes; VALUFlags are left unchanged at DONE.
- In EXEC and DONE:
  - start is ignored.
  - swe is ignored (no write).
  - srd still reads live storage.
- Reset mid-operation: return to IDLE at the next edge with no done pulse. Elements already written stay written; unwritten elements are unchanged.

Test Plan:
1. (WIDTH 32, VLEN 8, LANES 2) Load v1=[1..8], v2=[10,20..80]; start add ra1=1 ra2=2 wa3=3 vcount=8 → v3=[11,22..88]; done exactly 5 cycles after start; VALUFlags=0000.
2. Prefill v4 with 0xAAAAAAAA; sub ra1=1 ra2=1 wa3=4 vcount=3 → v4[0..2]=0, v4[3..7]=0xAAAAAAAA; done 3 cycles after start; flags N=0 Z=1 C=1 V=0.
3. v5[0]=0x7FFFFFFF, v6[0]=1; add vcount=1 → v7[0]=0x80000000; flags N=1 Z=0 C=0 V=1. Then v5[0]=0xFFFFFFFF add 1 → result 0, flags Z=1 C=1 V=0.
4. In-place add ra1=1 ra2=2 wa3=1 vcount=0 (treated as 8) → v1=[11,22..88]; srd on saddr=1 sidx=7 returns 88 after done.
5. During EXEC: pulse start with other operands, and swe to v2[0]=999 → neither takes effect; single done; v2[0] unchanged; ready low until after DONE.
6. Start add vcount=8, assert reset after 2 EXEC cycles → next cycle ready=1, done never pulses, dest elements 0..3 written, 4..7 hold prior values, VALUFlags=0000.
